// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the shared memory port between the static loader
// (bit0), command processor (bit1) and ROM reader (bit2). A registered one-hot
// grant owns the memory for one transfer, and a watchdog forces a release if
// memory never answers.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for rotating priority
// (default: fixed priority loader > cpu > reader).
module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] locator_0,
  input  logic [ADDR_W-1:0] locator_1,
  input  logic [ADDR_W-1:0] locator_2,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [DATA_W-1:0] wdata_2,
  output logic [2:0]        resp,
  output logic              mem_request,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_locator,
  output logic [DATA_W-1:0] mem_write,
  input  logic              mem_response,
  output logic [2:0]        grant,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Last count value of a transfer before the watchdog fires.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [2:0]  grant_nx;
  logic [15:0] cnt, cnt_nx;
  logic        terr_nx;
  logic        expire;
  logic [2:0]  winner;

  // Fixed priority: lowest requesting index wins.
  function automatic logic [2:0] pick_fixed(input logic [2:0] r);
    if (r[0])      return 3'b001;
    else if (r[1]) return 3'b010;
    else if (r[2]) return 3'b100;
    else           return 3'b000;
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [2:0] last;

  // Rotating priority: the search starts at the master after the last owner.
  function automatic logic [2:0] pick_rr(input logic [2:0] r, input logic [2:0] l);
    logic [2:0] w;
    w = 3'b000;
    case (l)
      3'b001: begin
        if (r[1])      w = 3'b010;
        else if (r[2]) w = 3'b100;
        else if (r[0]) w = 3'b001;
      end
      3'b010: begin
        if (r[2])      w = 3'b100;
        else if (r[0]) w = 3'b001;
        else if (r[1]) w = 3'b010;
      end
      default: w = pick_fixed(r);
    endcase
    return w;
  endfunction

  assign winner = pick_rr(req, last);

  // Remember the most recent owner; reset to reader so the loader wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 3'b100;
    else if (state == ST_IDLE && winner != 3'b000)
      last <= winner;
  end
`else
  assign winner = pick_fixed(req);
`endif

  assign expire = (state == ST_GRANT) && (cnt == CNT_LAST);

  // Control registers: state, owner, watchdog count and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= 3'b000;
      cnt         <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      cnt         <= cnt_nx;
      timeout_err <= terr_nx;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for answer or watchdog in GRANT,
  // hold ownership in RELEASE until the owner drops its request.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    cnt_nx   = cnt;
    terr_nx  = timeout_err;
    case (state)
      ST_IDLE: begin
        if (winner != 3'b000) begin
          grant_nx = winner;
          cnt_nx   = 16'd0;
          state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_nx = cnt + 16'd1;
        if (mem_response) begin
          state_nx = ST_RELEASE;
        end else if (expire) begin
          terr_nx  = 1'b1;
          state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if ((req & grant) == 3'b000) begin
          grant_nx = 3'b000;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        grant_nx = 3'b000;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Memory-side mux and response routing to the current owner only.
  always_comb begin
    mem_request = (state == ST_GRANT);
    mem_mode    = 1'b0;
    mem_locator = '0;
    mem_write   = '0;
    resp        = 3'b000;
    case (grant)
      3'b001: begin
        mem_mode    = mode[0];
        mem_locator = locator_0;
        mem_write   = wdata_0;
      end
      3'b010: begin
        mem_mode    = mode[1];
        mem_locator = locator_1;
        mem_write   = wdata_1;
      end
      3'b100: begin
        mem_mode    = mode[2];
        mem_locator = locator_2;
        mem_write   = wdata_2;
      end
      default: ;
    endcase
    if (state == ST_GRANT && (mem_response || expire))
      resp = grant;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter, built with TIMEOUT=4.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] locator_0, locator_1, locator_2;
  logic [DATA_W-1:0] wdata_0, wdata_1, wdata_2;
  logic [2:0]        resp;
  logic              mem_request;
  logic              mem_mode;
  logic [ADDR_W-1:0] mem_locator;
  logic [DATA_W-1:0] mem_write;
  logic              mem_response;
  logic [2:0]        grant;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .locator_0(locator_0), .locator_1(locator_1), .locator_2(locator_2),
    .wdata_0(wdata_0), .wdata_1(wdata_1), .wdata_2(wdata_2),
    .resp(resp), .mem_request(mem_request), .mem_mode(mem_mode),
    .mem_locator(mem_locator), .mem_write(mem_write),
    .mem_response(mem_response), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    req = 3'b000; mode = 3'b000; mem_response = 1'b0;
    locator_0 = '0; locator_1 = '0; locator_2 = '0;
    wdata_0 = '0; wdata_1 = '0; wdata_2 = '0;
    do_reset();

    // Reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_memreq", 32'(mem_request), 32'h0);
    check("rst_resp", 32'(resp), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    check("rst_loc", 32'(mem_locator), 32'h0);

    // Single cpu read, memory answers in the third GRANT cycle
    locator_1 = 16'h0040; req = 3'b010;
    tick();
    check("cpu_grant", 32'(grant), 32'h2);
    check("cpu_memreq", 32'(mem_request), 32'h1);
    check("cpu_loc", 32'(mem_locator), 32'h0040);
    check("cpu_resp_wait", 32'(resp), 32'h0);
    tick(); tick();
    mem_response = 1'b1; #1;
    check("cpu_resp", 32'(resp), 32'h2);
    tick();
    mem_response = 1'b0; #1;
    check("cpu_rel_memreq", 32'(mem_request), 32'h0);
    check("cpu_rel_grant", 32'(grant), 32'h2);
    check("cpu_rel_resp", 32'(resp), 32'h0);
    req = 3'b000;
    tick();
    check("cpu_idle_grant", 32'(grant), 32'h0);

    // Simultaneous requests from all three masters
    do_reset();
    locator_0 = 16'h1111; locator_1 = 16'h2222; locator_2 = 16'h3333;
    req = 3'b111;
    tick();
    check("sim_g0", 32'(grant), 32'h1);
    check("sim_loc0", 32'(mem_locator), 32'h1111);
    mem_response = 1'b1; #1;
    check("sim_resp0", 32'(resp), 32'h1);
    tick();
    mem_response = 1'b0; req = 3'b110;
    tick();
    check("sim_idle0", 32'(grant), 32'h0);
    tick();
    check("sim_g1", 32'(grant), 32'h2);
    check("sim_loc1", 32'(mem_locator), 32'h2222);
    mem_response = 1'b1; #1;
    check("sim_resp1", 32'(resp), 32'h2);
    tick();
    mem_response = 1'b0; req = 3'b100;
    tick();
    tick();
    check("sim_g2", 32'(grant), 32'h4);
    check("sim_loc2", 32'(mem_locator), 32'h3333);
    mem_response = 1'b1; #1;
    check("sim_resp2", 32'(resp), 32'h4);
    tick();
    mem_response = 1'b0; req = 3'b000;
    tick();

    // Loader write
    mode = 3'b001; wdata_0 = 16'hBEEF; #1;
    check("wr_idle_mode", 32'(mem_mode), 32'h0);
    check("wr_idle_data", 32'(mem_write), 32'h0);
    req = 3'b001;
    tick();
    check("wr_mode", 32'(mem_mode), 32'h1);
    check("wr_data", 32'(mem_write), 32'hBEEF);
    mem_response = 1'b1;
    tick();
    mem_response = 1'b0; req = 3'b000;
    tick();
    check("wr_after_mode", 32'(mem_mode), 32'h0);
    check("wr_after_data", 32'(mem_write), 32'h0);
    mode = 3'b000;

    // Watchdog: reader never answered, TIMEOUT=4
    req = 3'b100;
    tick();
    check("to_c0_resp", 32'(resp), 32'h0);
    tick(); tick();
    check("to_c2_resp", 32'(resp), 32'h0);
    tick();
    check("to_pulse", 32'(resp), 32'h4);
    check("to_err_pre", 32'(timeout_err), 32'h0);
    tick();
    check("to_err", 32'(timeout_err), 32'h1);
    check("to_rel_resp", 32'(resp), 32'h0);
    check("to_rel_memreq", 32'(mem_request), 32'h0);
    req = 3'b000;
    tick();
    check("to_idle_grant", 32'(grant), 32'h0);
    check("to_err_sticky", 32'(timeout_err), 32'h1);

    // Reset asserted during GRANT
    req = 3'b010;
    tick();
    check("rg_grant", 32'(grant), 32'h2);
    rst_n = 1'b0; #1;
    check("rg_grant0", 32'(grant), 32'h0);
    check("rg_memreq0", 32'(mem_request), 32'h0);
    check("rg_resp0", 32'(resp), 32'h0);
    check("rg_terr0", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rg_regrant", 32'(grant), 32'h2);
    mem_response = 1'b1;
    tick();
    mem_response = 1'b0; req = 3'b000;
    tick();

    // Requester drops early: transfer completes, RELEASE exits at once
    req = 3'b001;
    tick();
    req = 3'b000; mem_response = 1'b1; #1;
    check("pv_resp", 32'(resp), 32'h1);
    tick();
    mem_response = 1'b0;
    tick();
    check("pv_idle", 32'(grant), 32'h0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // cpu and reader re-requesting continuously alternate
    req = 3'b110;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h2 : 32'h4);
      mem_response = 1'b1;
      tick();
      mem_response = 1'b0;
      req = (k % 2 == 0) ? 3'b100 : 3'b010;
      tick();
      req = 3'b110;
    end
    req = 3'b000;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single shared memory port between the three bus masters: static loader, command processor and ROM reader. It replaces the current wired-OR of request/mode/locator/write lines with a registered grant, so only one master drives the memory at a time and overlapping requests are serialised instead of corrupting each other. It sits directly upstream of `memory`, between it and the masters. A watchdog releases the bus if memory never answers.

## Interface
Parameters:
- `ADDR_W`, 16: locator width.
- `DATA_W`, 16: write/read data width.
- `TIMEOUT`, 255: cycles in GRANT without `mem_response` before forced release; range 1..65535.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req[2:0]`  in  3: master requests; bit0 loader, bit1 cpu, bit2 reader.
- `mode[2:0]`  in  3: per-master mode flag (1 = write).
- `locator_0/1/2`  in  ADDR_W: per-master address.
- `wdata_0/1/2`  in  DATA_W: per-master write data; reader ties 0.
- `resp[2:0]`  out  3: per-master response, routed from memory to the granted master only.
- `mem_request`  out  1: to memory `request`.
- `mem_mode`  out  1: to memory `mode_flag`.
- `mem_locator`  out  ADDR_W: to memory `locator`.
- `mem_write`  out  DATA_W: to memory `write_bus`.
- `mem_response`  in  1: from memory `response`.
- `grant[2:0]`  out  3: one-hot current owner; 0 when idle.
- `timeout_err`  out  1: sticky watchdog flag.

`read_bus` is not routed through this block. It stays broadcast from memory to all masters.

## Operation
- Master protocol:
  - Raise `req[i]` with mode/locator/wdata stable.
  - Hold until `resp[i]` is seen high.
  - Drop `req[i]` before issuing the next request.
- States:
  - IDLE:
    - If any `req` bit is set, select a winner, load `grant` and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT:
    - `mem_request`=1.
    - Mem outputs mux the granted master's mode/locator/wdata.
    - `resp[g]` = `mem_response`, combinational.
    - On `mem_response`=1 go to RELEASE.
    - On watchdog expiry, set `timeout_err`, pulse `resp[g]` for one cycle and go to RELEASE.
  - RELEASE:
    - `mem_request`=0 and `grant` is held.
    - Stay until `req[g]`=0, then clear `grant` and go to IDLE.
- Outputs when `grant`=0: `mem_mode`, `mem_locator` and `mem_write` are driven 0.
- Non-granted `resp` bits are always 0.
- Default winner selection is fixed priority: loader > cpu > reader.
- A master whose `req` drops while in GRANT (protocol violation): the transfer continues to `mem_response` or timeout, then RELEASE exits immediately.
- The watchdog counter clears on entry to GRANT and increments each GRANT cycle. It expires when count == `TIMEOUT`-1.
- `timeout_err` clears only on reset.

## Timing
- Reset values: state IDLE, `grant`=0, `mem_request`=0, `resp`=0, `mem_mode`/`mem_locator`/`mem_write`=0, `timeout_err`=0, counter=0.
- Arbitration latency:
  - `req` sampled high at edge N.
  - `grant` and `mem_request` are registered high after edge N.
  - Memory sees the request from cycle N+1.
- Response path: `resp[g]` follows `mem_response` in the same cycle, combinational.
- After `mem_response`, `mem_request` is low in the next cycle. This guarantees one idle cycle before any re-grant.
- Minimum turnaround between grants is 2 cycles (RELEASE, then IDLE).
- Simultaneous requests are resolved in a single cycle. Losers hold `req` and are served on a later IDLE.
- `rst_n` asserted mid-transfer: all outputs return to their reset values asynchronously. The interrupted master must re-request.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: rotating priority. The search starts at the master after the last granted one (initial last = reader, so the loader wins first after reset). This prevents the cpu from starving the reader.
  - Undefined: fixed priority loader > cpu > reader, with no last-grant register.

## Test plan
- Single cpu read: `req`=3'b010, locator 16'h0040, memory answers after 3 cycles → `grant`=3'b010 one cycle after `req`; `mem_locator`=16'h0040; `resp[1]` pulses; `mem_request` low the cycle after.
- Simultaneous `req`=3'b111, fixed priority → grant order loader, cpu, reader; each `mem_locator` matches its owner; non-granted `resp` bits stay 0.
- With `MEM_ARB_ROUND_ROBIN_EN`, cpu and reader re-requesting continuously → grants alternate 3'b010, 3'b100, 3'b010, …
- Memory never responds, `TIMEOUT`=4 → `timeout_err`=1 after 4 GRANT cycles; `resp[g]` pulses once; block reaches IDLE after `req[g]` drops.
- Loader write `mode`=1, wdata 16'hBEEF → `mem_mode`=1 and `mem_write`=16'hBEEF during GRANT; both are 0 in IDLE.
- `rst_n` pulsed low during GRANT → `mem_request`, `grant`, `resp` and `timeout_err` are 0 immediately; the next request is granted normally.
